// File: rtl/ni_endpoint.sv
// Core-side network interface for a router's local port.
// The TX path injects credit-gated flits. The RX path buffers ejected flits and returns one credit per pop.
module ni_endpoint #(
  parameter int FLIT_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int CREDITS = 4,
  parameter int RXDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        myaddr_i,
  input  logic                     tx_valid_i,
  output logic                     tx_ready_o,
  input  logic [ADDR_W-1:0]        tx_dest_i,
  input  logic [FLIT_W-ADDR_W-1:0] tx_payload_i,
  output logic [FLIT_W-1:0]        local_o,
  output logic                     local_valid_o,
  input  logic                     credit_i,
  input  logic [FLIT_W-1:0]        local_i,
  input  logic                     local_valid_i,
  output logic                     credit_o,
  output logic                     rx_valid_o,
  input  logic                     rx_ready_i,
  output logic [FLIT_W-1:0]        rx_flit_o,
  output logic                     rx_overflow_o,
  output logic                     rx_misroute_o,
  output logic                     credit_err_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // ready never depends combinationally on the matching valid.

  localparam int CNT_W = $clog2(CREDITS + 1);
  localparam int OCC_W = $clog2(RXDEPTH + 1);
  localparam int PTR_W = (RXDEPTH > 1) ? $clog2(RXDEPTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CREDITS);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(RXDEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RXDEPTH - 1);

  // ---------------- TX ----------------
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cred_err_q, cred_err_d;
  logic [FLIT_W-1:0] local_q, local_d;
  logic              local_valid_q, local_valid_d;
  logic              send;

  assign tx_ready_o = (cnt_q != '0);
  assign send       = tx_valid_i & tx_ready_o;

  always_comb begin
    cnt_d         = cnt_q;
    cred_err_d    = cred_err_q;
    local_d       = local_q;
    local_valid_d = send;
    if (send) local_d = {tx_dest_i, tx_payload_i};
    case ({send, credit_i})
      2'b10: cnt_d = cnt_q - 1'b1;
      2'b01: begin
        // A surplus credit is an accounting error upstream; saturate and flag it.
        if (cnt_q == CNT_MAX) cred_err_d = 1'b1;
        else                  cnt_d      = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= CNT_MAX;
      cred_err_q    <= 1'b0;
      local_q       <= '0;
      local_valid_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      cred_err_q    <= cred_err_d;
      local_q       <= local_d;
      local_valid_q <= local_valid_d;
    end
  end

  assign local_o       = local_q;
  assign local_valid_o = local_valid_q;
  assign credit_err_o  = cred_err_q;

  // ---------------- RX ----------------
  logic [FLIT_W-1:0] mem_q [RXDEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic              ovf_q, ovf_d, mis_q, mis_d, credit_q;
  logic              full, push, pop;

  assign full       = (occ_q == OCC_FULL);
  assign rx_valid_o = (occ_q != '0);
  assign pop        = rx_valid_o & rx_ready_i;
  assign push       = local_valid_i & (~full | pop);
  assign rx_flit_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q;
    mis_d    = mis_q;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: ;
    endcase
    if (local_valid_i & ~push) ovf_d = 1'b1;
    if (push && (local_i[FLIT_W-1 -: ADDR_W] != myaddr_i)) mis_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= local_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      mis_q    <= 1'b0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      mis_q    <= mis_d;
      credit_q <= pop;
    end
  end

  assign credit_o      = credit_q;
  assign rx_overflow_o = ovf_q;
  assign rx_misroute_o = mis_q;

endmodule

// File: tb/tb_ni_endpoint.sv
// Directed bench for ni_endpoint: credit-gated TX, RX FIFO fill/drain, sticky flags, async reset.
module tb_ni_endpoint;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  myaddr_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  tx_dest_i;
  logic [23:0] tx_payload_i;
  logic [31:0] local_o;
  logic        local_valid_o;
  logic        credit_i;
  logic [31:0] local_i;
  logic        local_valid_i;
  logic        credit_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] rx_flit_o;
  logic        rx_overflow_o;
  logic        rx_misroute_o;
  logic        credit_err_o;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_flit;

  ni_endpoint dut (
    .clk(clk), .rst(rst), .myaddr_i(myaddr_i),
    .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o), .tx_dest_i(tx_dest_i),
    .tx_payload_i(tx_payload_i), .local_o(local_o), .local_valid_o(local_valid_o),
    .credit_i(credit_i), .local_i(local_i), .local_valid_i(local_valid_i),
    .credit_o(credit_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .rx_flit_o(rx_flit_o), .rx_overflow_o(rx_overflow_o),
    .rx_misroute_o(rx_misroute_o), .credit_err_o(credit_err_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic rx_push(input logic [31:0] flit);
    local_i       = flit;
    local_valid_i = 1'b1;
    tick();
    local_valid_i = 1'b0;
  endtask

  task automatic rx_drain_all();
    rx_ready_i = 1'b1;
    while (exp_q.size() != 0) begin
      exp_flit = exp_q.pop_front();
      check("rx_valid_drain", rx_valid_o, 1'b1);
      check("rx_flit_drain", rx_flit_o, exp_flit);
      tick();
      check("credit_o_pulse", credit_o, 1'b1);
    end
    check("rx_empty_after_drain", rx_valid_o, 1'b0);
    rx_ready_i = 1'b0;
    tick();
    check("credit_o_idle", credit_o, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; myaddr_i = 8'h12;
    tx_valid_i = 1'b0; tx_dest_i = 8'h12; tx_payload_i = '0;
    credit_i = 1'b0; local_i = '0; local_valid_i = 1'b0; rx_ready_i = 1'b0;
    #2;
    do_reset();

    // reset state
    check("rst_tx_ready", tx_ready_o, 1'b1);
    check("rst_local_valid", local_valid_o, 1'b0);
    check("rst_local_o", local_o, 32'h0);
    check("rst_credit_o", credit_o, 1'b0);
    check("rst_rx_valid", rx_valid_o, 1'b0);
    check("rst_flags", {rx_overflow_o, rx_misroute_o, credit_err_o}, 3'b000);
    check("rst_cnt", dut.cnt_q, 4);

    // credit exhaustion: four back-to-back sends
    tx_valid_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tx_payload_i = 24'(k);
      tick();
      check("tx_valid_k", local_valid_o, 1'b1);
      check("tx_flit_k", local_o, {8'h12, 24'(k)});
    end
    check("tx_ready_exhausted", tx_ready_o, 1'b0);
    tx_payload_i = 24'd5;
    tick();
    check("tx_blocked_valid", local_valid_o, 1'b0);
    check("tx_blocked_hold", local_o, {8'h12, 24'd4});
    credit_i = 1'b1;
    tick();
    credit_i = 1'b0;
    check("tx_no_send_at_zero", local_valid_o, 1'b0);
    check("tx_ready_after_credit", tx_ready_o, 1'b1);
    tick();
    check("tx_fifth_valid", local_valid_o, 1'b1);
    check("tx_fifth_flit", local_o, {8'h12, 24'd5});
    check("tx_ready_after_fifth", tx_ready_o, 1'b0);
    tx_valid_i = 1'b0;

    // simultaneous send and credit
    credit_i = 1'b1;
    tick();
    check("cnt_one", dut.cnt_q, 1);
    tx_valid_i = 1'b1; tx_payload_i = 24'd6;
    tick();
    tx_valid_i = 1'b0;
    check("simul_cnt", dut.cnt_q, 1);
    check("simul_ready", tx_ready_o, 1'b1);
    check("simul_sent", local_o, {8'h12, 24'd6});
    tick(); tick(); tick();
    check("cnt_full", dut.cnt_q, 4);
    check("no_err_yet", credit_err_o, 1'b0);
    tick();
    credit_i = 1'b0;
    check("err_cnt_sat", dut.cnt_q, 4);
    check("credit_err", credit_err_o, 1'b1);
    tick();
    check("credit_err_sticky", credit_err_o, 1'b1);

    // RX fill to full, overflow on 5th
    for (int i = 0; i < 4; i++) begin
      rx_push({8'h12, 24'hA0000 + 24'(i)});
      exp_q.push_back({8'h12, 24'hA0000 + 24'(i)});
    end
    check("rx_full_occ", dut.occ_q, 4);
    check("rx_head_fwft", rx_flit_o, {8'h12, 24'hA0000});
    check("no_ovf_yet", rx_overflow_o, 1'b0);
    rx_push({8'h12, 24'hEEEEE});
    check("rx_overflow", rx_overflow_o, 1'b1);
    check("rx_occ_after_drop", dut.occ_q, 4);
    check("no_misroute", rx_misroute_o, 1'b0);
    rx_drain_all();

    // full with simultaneous push/pop, plus misroute
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rx_push({8'h12, 24'hB0000 + 24'(i)});
      exp_q.push_back({8'h12, 24'hB0000 + 24'(i)});
    end
    rx_ready_i = 1'b1;
    check("pp_head", rx_flit_o, exp_q.pop_front());
    rx_push({8'h34, 24'hF0000});
    exp_q.push_back({8'h34, 24'hF0000});
    rx_ready_i = 1'b0;
    check("pp_occ", dut.occ_q, 4);
    check("pp_no_ovf", rx_overflow_o, 1'b0);
    check("misroute", rx_misroute_o, 1'b1);
    check("pp_credit", credit_o, 1'b1);
    rx_drain_all();
    check("misroute_sticky", rx_misroute_o, 1'b1);

    // reset mid-operation
    do_reset();
    tx_valid_i = 1'b1; tx_payload_i = 24'd7;
    local_i = {8'h12, 24'hC0000}; local_valid_i = 1'b1;
    tick(); tick();
    rx_ready_i = 1'b1;
    tick();
    tx_valid_i = 1'b0; local_valid_i = 1'b0; rx_ready_i = 1'b0;
    check("mid_cnt", dut.cnt_q, 1);
    check("mid_occ", dut.occ_q, 2);
    check("mid_credit_pending", credit_o, 1'b1);
    check("mid_local_valid", local_valid_o, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async_local_valid", local_valid_o, 1'b0);
    check("async_local_o", local_o, 32'h0);
    check("async_credit_o", credit_o, 1'b0);
    check("async_rx_valid", rx_valid_o, 1'b0);
    check("async_tx_ready", tx_ready_o, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_cnt", dut.cnt_q, 4);
    check("post_rst_rx_valid", rx_valid_o, 1'b0);
    check("post_rst_credit_o", credit_o, 1'b0);
    check("post_rst_flags", {rx_overflow_o, rx_misroute_o, credit_err_o}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ni_endpoint.md
Name: ni_endpoint

Overview:
- Network interface for the router's local port: the core-side end of the router's local link and credit protocol.
- TX side injects single-flit packets into the router's local input and tracks the credits the router returns on each local-buffer pop.
- RX side accepts flits ejected on the router's local output into an ejection FIFO. It returns one credit pulse per core pop, which drives the router's l_incr_i.

Parameters:
- FLIT_W, 32, flit width; flit = {dest[ADDR_W-1:0], payload[FLIT_W-ADDR_W-1:0]}, dest in MSBs.
- ADDR_W, 8, router address width.
- CREDITS, 4, depth of the router local input buffer; TX credit counter reset value.
- RXDEPTH, 4, ejection FIFO depth; must equal the router's local-output credit counter reset value.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- myaddr_i  in  ADDR_W  this node's address, compared against ejected flit dest.
- tx_valid_i  in  1  core offers a packet.
- tx_ready_o  out  1  endpoint can accept (credit available).
- tx_dest_i  in  ADDR_W  destination address.
- tx_payload_i  in  FLIT_W-ADDR_W  payload.
- local_o  out  FLIT_W  flit to the router's local input.
- local_valid_o  out  1  local_o valid this cycle.
- credit_i  in  1  one-cycle credit return pulse from the router (local input buffer popped).
- local_i  in  FLIT_W  flit ejected by the router's local output.
- local_valid_i  in  1  local_i valid this cycle.
- credit_o  out  1  one-cycle credit pulse to the router (l_incr_i).
- rx_valid_o  out  1  ejection FIFO head valid.
- rx_ready_i  in  1  core pops the head.
- rx_flit_o  out  FLIT_W  ejection FIFO head.
- rx_overflow_o  out  1  sticky: flit dropped because the FIFO was full.
- rx_misroute_o  out  1  sticky: ejected flit dest != myaddr_i.
- credit_err_o  out  1  sticky: credit_i received while the counter was at CREDITS.

Behaviour:
- Reset (async, immediate):
  - credit counter = CREDITS; FIFO empty.
  - local_o = 0, local_valid_o = 0, credit_o = 0, rx_valid_o = 0.
  - All sticky flags cleared.
  - A pending credit_o is discarded.
- TX credit counter:
  - Width $clog2(CREDITS+1).
  - tx_ready_o = (cnt != 0), decoded from the register only, with no combinational path from tx_valid_i.
  - send = tx_valid_i & tx_ready_o.
  - cnt_next = cnt - send + credit_i.
  - Simultaneous send and credit_i: counter unchanged.
  - credit_i with cnt == CREDITS and no send: counter holds at CREDITS, credit_err_o set.
- TX datapath:
  - On send, local_o <= {tx_dest_i, tx_payload_i} and local_valid_o <= 1; otherwise local_valid_o <= 0 and local_o holds.
  - Latency: 1 cycle from accept to local_valid_o.
  - Back-to-back sends allowed, one per cycle, while credits remain.
- RX FIFO:
  - RXDEPTH entries, circular, pointer wrap at RXDEPTH, occupancy counter $clog2(RXDEPTH+1).
  - First-word-fall-through: a flit written at edge N appears on rx_flit_o with rx_valid_o = 1 after edge N.
  - pop = rx_valid_o & rx_ready_i.
  - push = local_valid_i & (not full | pop): push while full with a simultaneous pop is accepted and occupancy is unchanged.
  - local_valid_i while full without pop: flit dropped, rx_overflow_o set. This is a protocol violation by the router.
  - Push into an empty FIFO with rx_ready_i high: no same-cycle bypass; the flit is popped the following cycle at the earliest.
  - Misroute: on push, if local_i[FLIT_W-1 -: ADDR_W] != myaddr_i then rx_misroute_o is set. The flit is still enqueued.
- Credit return:
  - credit_o <= pop, registered.
  - Exactly one 1-cycle pulse per popped flit, 1 cycle after the pop edge.
  - Consecutive pops give consecutive pulses.
- Sticky flags clear only on rst.

Test Plan:
- Reset: rst=1 then released → tx_ready_o=1, local_valid_o=0, credit_o=0, rx_valid_o=0, all flags 0, internal cnt=4.
- Credit exhaustion:
  - 4 consecutive sends (dest 8'h12, payloads 1..4) with no credit_i → local_valid_o high 4 cycles carrying payloads 1..4 in order; tx_ready_o=0 after the 4th.
  - A held tx_valid_i produces no flit.
  - One credit_i pulse → tx_ready_o=1 next cycle, the 5th flit is sent, then tx_ready_o=0.
- Simultaneous send and credit: cnt=1, tx_valid_i=1 and credit_i=1 in the same cycle → cnt stays 1, tx_ready_o stays 1. Separately, credit_i at cnt=4 → cnt=4, credit_err_o=1.
- RX fill/drain:
  - myaddr_i=8'h12, rx_ready_i=0, push 4 flits dest 8'h12 (payloads A..D) → full; 5th push dropped, rx_overflow_o=1.
  - Then rx_ready_i=1 → rx_flit_o = A, B, C, D on consecutive cycles; credit_o pulses 4 times, each 1 cycle after its pop; rx_valid_o=0 afterwards.
- Full with simultaneous push/pop: FIFO full, local_valid_i=1 and pop in the same cycle → new flit accepted, occupancy stays 4, no overflow flag. Misroute: flit dest 8'h34 with myaddr_i=8'h12 → enqueued, rx_misroute_o=1.
- Reset mid-operation: cnt=1, 2 flits queued, credit_o pending → assert rst between edges → outputs clear immediately; after release tx_ready_o=1 with cnt=4, rx_valid_o=0, no credit_o pulse.
